// File: rtl/width_16to8.sv
// 16-bit word to 8-bit byte down-converter with valid/ready on both sides.
// Optional skid buffer for full byte-rate streaming: define WIDTH_16TO8_SKID_EN.
module width_16to8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  output logic        ready_in,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic        byte_idx,
  input  logic        ready_out,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a posedge where valid and ready are both
  // high; a valid producer holds its data stable until that transfer occurs.

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_word;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_idx;
  logic        r_ready;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = valid_in && r_ready;
  assign w_out_xfer = r_valid && ready_out;

  function automatic logic [7:0] f_first(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] f_second(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

`ifdef WIDTH_16TO8_SKID_EN
  logic [15:0] r_skid;
  logic        r_skid_full;
  logic        w_skid_full_nxt;
  logic        w_reload;

  // Reload path: the last byte of a word leaves and another word is waiting.
  assign w_reload = (r_state == S_SECOND) && w_out_xfer;

  always_comb begin
    w_skid_full_nxt = r_skid_full;
    if (w_reload && r_skid_full)
      w_skid_full_nxt = w_in_xfer;
    else if (w_in_xfer && (r_state != S_EMPTY) && !w_reload)
      w_skid_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_word      <= 16'h0000;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_idx       <= 1'b0;
      r_ready     <= 1'b1;
      r_skid      <= 16'h0000;
      r_skid_full <= 1'b0;
    end else begin
      r_skid_full <= w_skid_full_nxt;
      r_ready     <= !w_skid_full_nxt;
      if (w_in_xfer && (r_state != S_EMPTY) && !(w_reload && !r_skid_full))
        r_skid <= data_in;
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_word  <= data_in;
            r_data  <= f_first(data_in);
            r_idx   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (w_out_xfer) begin
            r_data  <= f_second(r_word);
            r_idx   <= 1'b1;
            r_state <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (w_out_xfer) begin
            r_idx <= 1'b0;
            if (r_skid_full) begin
              r_word  <= r_skid;
              r_data  <= f_first(r_skid);
              r_state <= S_FIRST;
            end else if (w_in_xfer) begin
              r_word  <= data_in;
              r_data  <= f_first(data_in);
              r_state <= S_FIRST;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_EMPTY;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_word  <= 16'h0000;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_idx   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_word  <= data_in;
            r_data  <= f_first(data_in);
            r_idx   <= 1'b0;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (w_out_xfer) begin
            r_data  <= f_second(r_word);
            r_idx   <= 1'b1;
            r_state <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (w_out_xfer) begin
            r_valid <= 1'b0;
            r_idx   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end
`endif

  assign ready_in  = r_ready;
  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign byte_idx  = r_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_width_16to8.sv
// Bench for width_16to8: two instances (MSB-first and LSB-first) share stimulus;
// table-driven single-word vectors plus streaming and mid-word reset sequences.
module tb_width_16to8;

`ifdef WIDTH_16TO8_SKID_EN
  localparam logic SK = 1'b1;
`else
  localparam logic SK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_out;

  logic        m_ready_in, m_valid_out, m_byte_idx;
  logic [7:0]  m_data_out;
  logic [1:0]  m_dbg_state;
  logic        l_ready_in, l_valid_out, l_byte_idx;
  logic [7:0]  l_data_out;
  logic [1:0]  l_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] up_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_ql[$];
  logic [7:0]  got_q[$];
  logic [7:0]  got_ql[$];
  int          cyc_q[$];

  width_16to8 #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready_in(m_ready_in), .valid_out(m_valid_out), .data_out(m_data_out),
    .byte_idx(m_byte_idx), .ready_out(ready_out), .dbg_state(m_dbg_state)
  );

  width_16to8 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready_in(l_ready_in), .valid_out(l_valid_out), .data_out(l_data_out),
    .byte_idx(l_byte_idx), .ready_out(ready_out), .dbg_state(l_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic [15:0] d;
    logic        ro;
    logic        ev;
    logic [7:0]  em;
    logic [7:0]  el;
    logic        eidx;
    logic        eri;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, " m_valid"}, {31'd0, m_valid_out}, 32'd0);
    chk({tag, " m_data"},  {24'd0, m_data_out}, 32'h00);
    chk({tag, " m_idx"},   {31'd0, m_byte_idx}, 32'd0);
    chk({tag, " m_ready"}, {31'd0, m_ready_in}, 32'd1);
    chk({tag, " m_state"}, {30'd0, m_dbg_state}, 32'd0);
    chk({tag, " l_valid"}, {31'd0, l_valid_out}, 32'd0);
    chk({tag, " l_data"},  {24'd0, l_data_out}, 32'h00);
  endtask

  // Drives up_q words with ready_out=1, records every output byte and the cycle seen.
  task automatic run_stream(input int max_cyc);
    got_q.delete(); got_ql.delete(); cyc_q.delete();
    ready_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      logic acc;
      if (m_valid_out) begin
        got_q.push_back(m_data_out);
        got_ql.push_back(l_data_out);
        cyc_q.push_back(c);
      end
      valid_in = (up_q.size() != 0);
      data_in  = (up_q.size() != 0) ? up_q[0] : 16'h0000;
      acc = valid_in && m_ready_in;
      @(posedge clk);
      if (acc) void'(up_q.pop_front());
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic score_stream(input string tag);
    chk({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s msb_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      chk($sformatf("%s lsb_byte%0d", tag, i), {24'd0, got_ql[i]}, {24'd0, exp_ql[i]});
    end
    chk({tag, " upstream_drained"}, up_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = 16'h0000; ready_out = 1'b0;

    // single-word vectors: word A55A, backpressured A55A, then BEEF
    vecs[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1, SK};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'hA55A, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, SK};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1, SK};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 16'hBEEF, 1'b1, 1'b1, 8'hBE, 8'hEF, 1'b0, SK};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hEF, 8'hBE, 1'b1, SK};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_reset("post_reset");

    for (int i = 0; i < 13; i++) begin
      valid_in  = vecs[i].vi;
      data_in   = vecs[i].d;
      ready_out = vecs[i].ro;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d m_valid", i), {31'd0, m_valid_out}, {31'd0, vecs[i].ev});
      chk($sformatf("row%0d l_valid", i), {31'd0, l_valid_out}, {31'd0, vecs[i].ev});
      chk($sformatf("row%0d ready_in", i), {31'd0, m_ready_in}, {31'd0, vecs[i].eri});
      if (vecs[i].ev) begin
        chk($sformatf("row%0d m_data", i), {24'd0, m_data_out}, {24'd0, vecs[i].em});
        chk($sformatf("row%0d l_data", i), {24'd0, l_data_out}, {24'd0, vecs[i].el});
        chk($sformatf("row%0d idx", i), {31'd0, m_byte_idx}, {31'd0, vecs[i].eidx});
      end
    end
    valid_in = 1'b0;

    // two-word stream: byte order and cycle spacing
    up_q = '{16'h1234, 16'h5678};
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_ql = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_stream(10);
    score_stream("stream");
    if (cyc_q.size() == 4) begin
      chk("stream first_latency", cyc_q[0], 1);
      chk("stream gap01", cyc_q[1] - cyc_q[0], 1);
      chk("stream gap12", cyc_q[2] - cyc_q[1], SK ? 1 : 2);
      chk("stream gap23", cyc_q[3] - cyc_q[2], 1);
    end

    // reset while a first byte is held under backpressure
    valid_in = 1'b1; data_in = 16'hBEEF; ready_out = 1'b0;
    @(posedge clk); @(negedge clk);
    valid_in = 1'b0;
    chk("held l_data", {24'd0, l_data_out}, 32'hEF);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_reset("after_release");

    up_q = '{16'h0102};
    exp_q = '{8'h01, 8'h02};
    exp_ql = '{8'h02, 8'h01};
    run_stream(8);
    score_stream("post_reset_word");
    if (cyc_q.size() == 2) chk("post_reset_word gap", cyc_q[1] - cyc_q[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
